move_controller: RTL and testbench

- Initiator side of the board-modification interface: converts mouse clicks on board squares into single-cycle pick/place command pulses for the board storage block.
- Reads the square under the cursor through the board's registered read port.
- Enforces side-to-move, legal-destination check against the move generator's 64-bit mask, cancel-by-reclick, turn toggling, capture reporting and game-over on king capture.
- Sits between the mouse/cursor logic and the board storage block.

---
 rtl/move_controller.sv | 151 +++++++++++++++
 tb/tb_move_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
// Move controller: turns mouse clicks on board squares into pick/place command pulses
// for the board storage block, enforcing side-to-move, legal destinations and game over.
module move_controller #(
    parameter int unsigned LOOKUP_LAT = 2,
    parameter logic [3:0]  WHITE_KING = 4'h6,
    parameter logic [3:0]  BLACK_KING = 4'hC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        click,
    input  logic [5:0]  cursor_pos,
    input  logic [3:0]  figure_code,
    input  logic [63:0] possible_moves,
    output logic [5:0]  figure_xy,
    output logic [5:0]  figure_position,
    output logic        pick_piece,
    output logic        place_piece,
    output logic        turn,
    output logic        holding,
    output logic [5:0]  sel_pos,
    output logic        move_done,
    output logic [3:0]  captured_code,
    output logic        game_over
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] PICK    = 3'd2;
    localparam logic [2:0] HELD    = 3'd3;
    localparam logic [2:0] LOOKUP2 = 3'd4;
    localparam logic [2:0] PLACE   = 3'd5;

    localparam logic [7:0] LAT = 8'(LOOKUP_LAT);
    localparam logic [3:0] EMPTY_HL = 4'hD;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] lat_q, lat_d;
    logic [5:0] pos_d;
    logic       legal_q, legal_d;
    logic [3:0] dest_q, dest_d;
    logic       click_q;
    logic       click_edge;
    logic       own_piece;
    logic       wait_done;

    assign click_edge = click & ~click_q;
    assign wait_done  = (cnt_q == LAT);
    assign own_piece  = turn ? (figure_code >= 4'h7 && figure_code <= 4'hC)
                             : (figure_code >= 4'h1 && figure_code <= 4'h6);

    // While a lookup is pending the read address must stay on the clicked square.
    assign figure_xy   = (state_q == LOOKUP || state_q == LOOKUP2) ? lat_q : cursor_pos;
    assign pick_piece  = (state_q == PICK);
    assign place_piece = (state_q == PLACE);
    assign move_done   = (state_q == PLACE) && legal_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        pos_d   = figure_position;
        legal_d = legal_q;
        dest_d  = dest_q;
        case (state_q)
            IDLE: begin
                if (click_edge && !game_over) begin
                    lat_d   = cursor_pos;
                    cnt_d   = 8'd0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!wait_done) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (own_piece) begin
                    pos_d   = lat_q;
                    state_d = PICK;
                end else begin
                    state_d = IDLE;
                end
            end
            PICK: state_d = HELD;
            HELD: begin
                if (click_edge && !game_over) begin
                    lat_d   = cursor_pos;
                    cnt_d   = 8'd0;
                    state_d = LOOKUP2;
                end
            end
            LOOKUP2: begin
                if (!wait_done) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (lat_q == sel_pos) begin
                    pos_d   = sel_pos;
                    legal_d = 1'b0;
                    state_d = PLACE;
                end else if (possible_moves[lat_q]) begin
                    pos_d   = lat_q;
                    legal_d = 1'b1;
                    dest_d  = (figure_code == EMPTY_HL) ? 4'h0 : figure_code;
                    state_d = PLACE;
                end else begin
                    state_d = HELD;
                end
            end
            PLACE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            lat_q           <= 6'd0;
            legal_q         <= 1'b0;
            dest_q          <= 4'h0;
            click_q         <= 1'b0;
            figure_position <= 6'd0;
            turn            <= 1'b0;
            holding         <= 1'b0;
            sel_pos         <= 6'd0;
            captured_code   <= 4'h0;
            game_over       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            lat_q           <= lat_d;
            legal_q         <= legal_d;
            dest_q          <= dest_d;
            click_q         <= click;
            figure_position <= pos_d;
            if (state_q == PICK) begin
                sel_pos <= lat_q;
                holding <= 1'b1;
            end
            if (state_q == PLACE) begin
                holding <= 1'b0;
                if (legal_q) begin
                    turn          <= ~turn;
                    captured_code <= dest_q;
                    if (dest_q == WHITE_KING || dest_q == BLACK_KING) begin
                        game_over <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: table of click transactions against a static board
// with a 3-cycle read latency, plus hand sequences for reset and held-button behaviour.
module tb_move_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        click = 1'b0;
    logic [5:0]  cursor_pos = 6'd0;
    logic [3:0]  figure_code;
    logic [63:0] possible_moves = 64'd0;
    logic [5:0]  figure_xy;
    logic [5:0]  figure_position;
    logic        pick_piece, place_piece, turn, holding, move_done, game_over;
    logic [5:0]  sel_pos;
    logic [3:0]  captured_code;

    int total = 0;
    int bad = 0;
    int pick_n = 0, place_n = 0, md_n = 0, both_n = 0;

    logic [3:0] board [64];
    logic [5:0] xy1 = 6'd0, xy2 = 6'd0, xy3 = 6'd0;

    always #5 clk = ~clk;

    move_controller dut (
        .clk            (clk),
        .rst            (rst),
        .click          (click),
        .cursor_pos     (cursor_pos),
        .figure_code    (figure_code),
        .possible_moves (possible_moves),
        .figure_xy      (figure_xy),
        .figure_position(figure_position),
        .pick_piece     (pick_piece),
        .place_piece    (place_piece),
        .turn           (turn),
        .holding        (holding),
        .sel_pos        (sel_pos),
        .move_done      (move_done),
        .captured_code  (captured_code),
        .game_over      (game_over)
    );

    // Board read model: data appears three clocks after the address.
    always @(posedge clk) begin
        xy1 <= figure_xy;
        xy2 <= xy1;
        xy3 <= xy2;
    end
    assign figure_code = board[xy3];

    always @(negedge clk) begin
        if (pick_piece) pick_n++;
        if (place_piece) place_n++;
        if (move_done) md_n++;
        if (pick_piece && place_piece) both_n++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  cur;
        logic [63:0] mask;
        int          n_pick;
        int          n_place;
        int          n_md;
        logic [5:0]  pos;
        logic        trn;
        logic        hold;
        logic [5:0]  sel;
        logic [3:0]  cap;
        logic        go;
    } vec_t;

    vec_t vecs [12];
    int p0, q0, m0;

    task automatic click_once(input logic [5:0] cur, input logic [63:0] mask);
        @(posedge clk); #1;
        cursor_pos = cur;
        possible_moves = mask;
        @(posedge clk); #1;
        click = 1'b1;
        @(posedge clk); #1;
        click = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " figure_xy"}, 64'(figure_xy), 64'd0);
        chk({tag, " figure_position"}, 64'(figure_position), 64'd0);
        chk({tag, " pick/place"}, 64'({pick_piece, place_piece, move_done}), 64'd0);
        chk({tag, " turn/holding/game_over"}, 64'({turn, holding, game_over}), 64'd0);
        chk({tag, " sel_pos/captured"}, 64'({sel_pos, captured_code}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) board[i] = 4'h0;
        board[6'o60] = 4'h1;
        board[6'o70] = 4'h4;
        board[6'o10] = 4'h7;
        board[6'o41] = 4'h1;
        board[6'o05] = 4'hC;
        board[6'o61] = 4'h1;
        board[6'o51] = 4'hD;

        //          cur    mask             pk pl md pos    trn  hold sel    cap   go
        vecs[0]  = '{6'o60, 64'd0,           1, 0, 0, 6'o60, 1'b0, 1'b1, 6'o60, 4'h0, 1'b0};
        vecs[1]  = '{6'o40, 64'h1 << 6'o40,  0, 1, 1, 6'o40, 1'b1, 1'b0, 6'o60, 4'h0, 1'b0};
        vecs[2]  = '{6'o70, 64'd0,           0, 0, 0, 6'o40, 1'b1, 1'b0, 6'o60, 4'h0, 1'b0};
        vecs[3]  = '{6'o50, 64'd0,           0, 0, 0, 6'o40, 1'b1, 1'b0, 6'o60, 4'h0, 1'b0};
        vecs[4]  = '{6'o10, 64'd0,           1, 0, 0, 6'o10, 1'b1, 1'b1, 6'o10, 4'h0, 1'b0};
        vecs[5]  = '{6'o20, 64'd0,           0, 0, 0, 6'o10, 1'b1, 1'b1, 6'o10, 4'h0, 1'b0};
        vecs[6]  = '{6'o10, 64'd0,           0, 1, 0, 6'o10, 1'b1, 1'b0, 6'o10, 4'h0, 1'b0};
        vecs[7]  = '{6'o10, 64'd0,           1, 0, 0, 6'o10, 1'b1, 1'b1, 6'o10, 4'h0, 1'b0};
        vecs[8]  = '{6'o20, 64'h1 << 6'o20,  0, 1, 1, 6'o20, 1'b0, 1'b0, 6'o10, 4'h0, 1'b0};
        vecs[9]  = '{6'o41, 64'd0,           1, 0, 0, 6'o41, 1'b0, 1'b1, 6'o41, 4'h0, 1'b0};
        vecs[10] = '{6'o05, 64'h1 << 6'o05,  0, 1, 1, 6'o05, 1'b1, 1'b0, 6'o41, 4'hC, 1'b1};
        vecs[11] = '{6'o10, 64'd0,           0, 0, 0, 6'o05, 1'b1, 1'b0, 6'o41, 4'hC, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            p0 = pick_n; q0 = place_n; m0 = md_n;
            click_once(vecs[i].cur, vecs[i].mask);
            chk($sformatf("v%0d pick count", i), 64'(pick_n - p0), 64'(vecs[i].n_pick));
            chk($sformatf("v%0d place count", i), 64'(place_n - q0), 64'(vecs[i].n_place));
            chk($sformatf("v%0d move_done count", i), 64'(md_n - m0), 64'(vecs[i].n_md));
            chk($sformatf("v%0d figure_position", i), 64'(figure_position), 64'(vecs[i].pos));
            chk($sformatf("v%0d turn", i), 64'(turn), 64'(vecs[i].trn));
            chk($sformatf("v%0d holding", i), 64'(holding), 64'(vecs[i].hold));
            chk($sformatf("v%0d sel_pos", i), 64'(sel_pos), 64'(vecs[i].sel));
            chk($sformatf("v%0d captured_code", i), 64'(captured_code), 64'(vecs[i].cap));
            chk($sformatf("v%0d game_over", i), 64'(game_over), 64'(vecs[i].go));
        end

        // Fresh game, lift a piece, then reset while holding it with the button going down.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        click_once(6'o61, 64'd0);
        chk("pre-reset holding", 64'(holding), 64'd1);
        q0 = place_n;
        cursor_pos = 6'o00;
        rst = 1'b1;
        click = 1'b1;
        #1;
        chk_outputs_zero("mid-hold reset");
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("held reset");
        chk("no place on reset", 64'(place_n - q0), 64'd0);
        cursor_pos = 6'o61;
        p0 = pick_n;
        #2;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        click = 1'b0;
        chk("one edge after reset: picks", 64'(pick_n - p0), 64'd1);
        chk("one edge after reset: holding", 64'(holding), 64'd1);
        chk("one edge after reset: sel_pos", 64'(sel_pos), 64'(6'o61));

        // Destination reads as highlighted-empty code D.
        p0 = pick_n; q0 = place_n; m0 = md_n;
        click_once(6'o51, 64'h1 << 6'o51);
        chk("D dest place count", 64'(place_n - q0), 64'd1);
        chk("D dest move_done", 64'(md_n - m0), 64'd1);
        chk("D dest captured_code", 64'(captured_code), 64'd0);
        chk("D dest position", 64'(figure_position), 64'(6'o51));
        chk("D dest turn", 64'(turn), 64'd1);
        chk("D dest game_over", 64'(game_over), 64'd0);
        chk("pick/place overlap", 64'(both_n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
